issue_ctrl: RTL

Scoreboard-based issue controller between the ID and EX stages of the 16-bit pipeline. It tracks in-flight register writes and decides each cycle whether the decoded instruction may issue or must stall. It serializes control flow by holding issue until a branch or jump resolves, and it drains the pipeline on halt. It drives the IF/ID hold, the ID/EX bubble insertion and the IF/ID flush.

---
 rtl/issue_ctrl_if.sv | 41 ++++
 rtl/issue_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/issue_ctrl_if.sv
// Handshake bundle between ID-stage decode, writeback and the issue controller.
// The controller attaches to the slave modport; the decode/EX side drives the master.
interface issue_ctrl_if #(
   parameter int NREG = 16
);
   localparam int RW = $clog2(NREG);

   logic            i_valid;
   logic [RW-1:0]   i_rdReg1;
   logic [RW-1:0]   i_rdReg2;
   logic            i_rdReg1En;
   logic            i_rdReg2En;
   logic [RW-1:0]   i_wrReg;
   logic            i_wrRegEn;
   logic            i_sawBr;
   logic            i_sawJ;
   logic            i_hlt;
   logic [RW-1:0]   i_wbReg;
   logic            i_wbEn;
   logic            i_brResolve;
   logic            i_brTaken;
   logic            o_issue;
   logic            o_stall;
   logic            o_flush;
   logic            o_halted;
   logic [NREG-1:0] o_pendMask;

   modport master (
      output i_valid, i_rdReg1, i_rdReg2, i_rdReg1En, i_rdReg2En,
             i_wrReg, i_wrRegEn, i_sawBr, i_sawJ, i_hlt,
             i_wbReg, i_wbEn, i_brResolve, i_brTaken,
      input  o_issue, o_stall, o_flush, o_halted, o_pendMask
   );

   modport slave (
      input  i_valid, i_rdReg1, i_rdReg2, i_rdReg1En, i_rdReg2En,
             i_wrReg, i_wrRegEn, i_sawBr, i_sawJ, i_hlt,
             i_wbReg, i_wbEn, i_brResolve, i_brTaken,
      output o_issue, o_stall, o_flush, o_halted, o_pendMask
   );
endinterface

// File: rtl/issue_ctrl.sv
// ID->EX issue controller: per-register pending-write scoreboard with RAW and
// structural interlock, branch/jump serialization and halt drain.
module issue_ctrl #(
   parameter int NREG      = 16,
   parameter int CNT_W     = 2,
   parameter int WB_BYPASS = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   issue_ctrl_if.slave bus
);
   localparam int RW = $clog2(NREG);

   typedef enum logic [1:0] {RUN, BR_WAIT, DRAIN, HALTED} state_t;

   state_t           state;
   state_t           stateNxt;
   logic [CNT_W-1:0] cnt    [NREG];
   logic [CNT_W-1:0] cntNxt [NREG];
   logic [NREG-1:0]  pendNow;
   logic [NREG-1:0]  pendMask;
   logic             rawHaz;
   logic             structHaz;
   logic             issue;
   logic             stall;
   logic             flush;
   logic             halted;
   logic             incEn;
   logic             decEn;
   logic             allZero;

   // Simultaneous issue and retire of one register cancel; retire at zero is dropped.
   function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cur,
                                                   input logic inc, input logic dec);
      if (inc && dec) return cur;
      if (inc) return cur + CNT_W'(1);
      if (dec && cur != '0) return cur - CNT_W'(1);
      return cur;
   endfunction

   // A last outstanding write retiring this cycle is visible through the register file.
   always_comb begin
      pendNow = '0;
      for (int r = 1; r < NREG; r++) begin
         pendNow[r] = (cnt[r] != '0) &&
                      !((WB_BYPASS != 0) && bus.i_wbEn && (bus.i_wbReg == RW'(r)) &&
                        (cnt[r] == CNT_W'(1)));
      end
   end

   assign rawHaz    = (bus.i_rdReg1En && pendNow[bus.i_rdReg1]) ||
                      (bus.i_rdReg2En && pendNow[bus.i_rdReg2]);
   assign structHaz = bus.i_wrRegEn && (bus.i_wrReg != '0) && (cnt[bus.i_wrReg] == '1);
   assign allZero   = ~|pendMask;

   always_comb begin
      stateNxt = state;
      issue    = 1'b0;
      stall    = 1'b1;
      flush    = 1'b0;
      halted   = 1'b0;
      case (state)
         RUN: begin
            issue = bus.i_valid && !rawHaz && !structHaz;
            stall = bus.i_valid && !issue;
            if (issue && (bus.i_sawBr || bus.i_sawJ)) stateNxt = BR_WAIT;
            else if (issue && bus.i_hlt)             stateNxt = DRAIN;
         end
         BR_WAIT: begin
            if (bus.i_brResolve) begin
               stateNxt = RUN;
               flush    = bus.i_brTaken;
            end
         end
         DRAIN: begin
            if (allZero) stateNxt = HALTED;
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: stateNxt = RUN;
      endcase
      if (i_rst) begin
         issue  = 1'b0;
         stall  = 1'b1;
         flush  = 1'b0;
         halted = 1'b0;
      end
   end

   assign incEn = issue && bus.i_wrRegEn && (bus.i_wrReg != '0);
   assign decEn = bus.i_wbEn && (bus.i_wbReg != '0);

   always_comb begin
      for (int r = 0; r < NREG; r++) cntNxt[r] = '0;
      for (int r = 1; r < NREG; r++) begin
         cntNxt[r] = nextCount(cnt[r], incEn && (bus.i_wrReg == RW'(r)),
                               decEn && (bus.i_wbReg == RW'(r)));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= RUN;
         pendMask <= '0;
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         state <= stateNxt;
         for (int r = 0; r < NREG; r++) begin
            cnt[r]      <= cntNxt[r];
            pendMask[r] <= (cntNxt[r] != '0);
         end
      end
   end

   assign bus.o_issue    = issue;
   assign bus.o_stall    = stall;
   assign bus.o_flush    = flush;
   assign bus.o_halted   = halted;
   assign bus.o_pendMask = pendMask;
endmodule
